// File: rtl/des_key_sched_seq_if.sv
// Handshake bundle between a key source, the sequential DES key scheduler
// and the single-round DES datapath that consumes one round key per round.
interface des_key_sched_seq_if;
    logic [63:0] KEY;
    logic        key_load;
    logic        mode_override;
    logic        mode_decrypt;
    logic        rk_ready;
    logic        rk_valid;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        rk_last;
    logic        busy;

    modport master (
        output KEY, key_load, mode_override, mode_decrypt, rk_ready,
        input  rk_valid, round_key, round_idx, rk_last, busy
    );

    modport slave (
        input  KEY, key_load, mode_override, mode_decrypt, rk_ready,
        output rk_valid, round_key, round_idx, rk_last, busy
    );
endinterface

// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler: one 48-bit round key per valid/ready transfer,
// K1..K16 (encrypt, rotate left) or K16..K1 (decrypt, rotate right).
module des_key_sched_seq #(
    parameter bit DECRYPT_DEFAULT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_sched_seq_if.slave   bus
);

    // Tables use DES 1-based bit numbering; DES bit n of a w-bit vector is bit [w-n].
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int j = 0; j < 56; j++) o[55-j] = k[64-PC1_T[j]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_T[j]];
        return o;
    endfunction

    // Shift for round (n+1): rounds 1, 2, 9 and 16 shift by one, the rest by two.
    function automatic logic [1:0] shamt(input logic [3:0] n);
        return (n == 4'd0 || n == 4'd1 || n == 4'd8 || n == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_idx;
    logic        r_dec;
    logic        w_mode;
    logic        w_last;
    logic        w_xfer;
    logic [55:0] w_pc1;

    assign w_pc1  = pc1(bus.KEY);
    assign w_mode = bus.mode_override ? bus.mode_decrypt : DECRYPT_DEFAULT;
    assign w_last = (r_state == S_EMIT) && (r_dec ? (r_idx == 4'd0) : (r_idx == 4'd15));
    assign w_xfer = (r_state == S_EMIT) && bus.rk_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.key_load)     w_next = S_EMIT;
            S_EMIT: if (w_xfer && w_last) w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rk_valid = 1'b0;
        bus.busy     = 1'b0;
        bus.rk_last  = 1'b0;
        if (r_state == S_EMIT) begin
            bus.rk_valid = 1'b1;
            bus.busy     = 1'b1;
            bus.rk_last  = w_last;
        end
    end

    assign bus.round_key = pc2({r_c, r_d});
    assign bus.round_idx = r_idx;

    // Encrypt skips the shift on its final transfer so both modes finish at PC-1 (28 total).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c   <= '0;
            r_d   <= '0;
            r_idx <= '0;
            r_dec <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.key_load) begin
                r_dec <= w_mode;
                if (w_mode) begin
                    r_c   <= w_pc1[55:28];
                    r_d   <= w_pc1[27:0];
                    r_idx <= 4'd15;
                end else begin
                    r_c   <= rotl(w_pc1[55:28], 2'd1);
                    r_d   <= rotl(w_pc1[27:0], 2'd1);
                    r_idx <= 4'd0;
                end
            end
        end else if (w_xfer) begin
            if (r_dec) begin
                r_c <= rotr(r_c, shamt(r_idx));
                r_d <= rotr(r_d, shamt(r_idx));
                if (!w_last) r_idx <= r_idx - 4'd1;
            end else if (!w_last) begin
                r_c   <= rotl(r_c, shamt(r_idx + 4'd1));
                r_d   <= rotl(r_d, shamt(r_idx + 4'd1));
                r_idx <= r_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench for des_key_sched_seq: reference key-schedule model feeds a
// scoreboard queue that is drained as the DUT hands over round keys.
module tb_des_key_sched_seq;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] K0  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1  = 64'h123456789ABCDEF0;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_key_sched_seq_if bus ();

    des_key_sched_seq #(.DECRYPT_DEFAULT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t        sb [$];
    logic [47:0] got [16];
    logic [47:0] sav [16];
    int          n_xfer;
    int          n_cyc;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [55:0] m_pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int j = 0; j < 56; j++) o[55-j] = k[64-PC1_T[j]];
        return o;
    endfunction

    // Round r (1..16) key computed directly from the cumulative left shift.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        int          sh;
        cd = m_pc1(k);
        c  = cd[55:28];
        d  = cd[27:0];
        sh = 0;
        for (int n = 0; n < r; n++) sh += SH[n];
        for (int t = 0; t < sh; t++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        o  = '0;
        for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_T[j]];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sched(input logic [63:0] k, input bit dec);
        int r;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            r      = dec ? 16 - i : i + 1;
            e.key  = ref_key(k, r);
            e.idx  = 4'(r - 1);
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    task automatic run(input logic [63:0] k, input bit ovr, input bit mdec, input bit dec,
                       input int rdy_pct, input int inj_at, input int abort_at, input bit b2b);
        exp_t        e;
        logic [47:0] pk;
        logic [3:0]  pi;
        logic        pl;
        bit          stalled;
        bit          rdy;
        bit          aborted;
        stalled = 1'b0;
        aborted = 1'b0;
        pk = '0; pi = '0; pl = 1'b0;
        n_xfer = 0;
        n_cyc  = 0;
        bus.KEY           = k;
        bus.mode_override = ovr;
        bus.mode_decrypt  = mdec;
        bus.rk_ready      = 1'b0;
        bus.key_load      = 1'b1;
        push_sched(k, dec);
        tick();
        bus.key_load = 1'b0;
        chk("first_valid", 64'(bus.rk_valid), 64'd1);
        chk("first_busy", 64'(bus.busy), 64'd1);
        while (n_xfer < 16 && n_cyc < 400) begin
            if (stalled) begin
                chk("stall_valid", 64'(bus.rk_valid), 64'd1);
                chk("stall_key", 64'(bus.round_key), 64'(pk));
                chk("stall_idx", 64'(bus.round_idx), 64'(pi));
                chk("stall_last", 64'(bus.rk_last), 64'(pl));
            end
            rdy = ($urandom_range(99) < rdy_pct);
            bus.rk_ready = rdy;
            if (bus.rk_valid && rdy) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("key", 64'(bus.round_key), 64'(e.key));
                    chk("idx", 64'(bus.round_idx), 64'(e.idx));
                    chk("last", 64'(bus.rk_last), 64'(e.last));
                end
                got[n_xfer] = bus.round_key;
                n_xfer++;
                stalled = 1'b0;
                if (b2b && n_xfer == 16) bus.key_load = 1'b1;
                if (n_xfer == inj_at) begin
                    bus.key_load = 1'b1;
                    bus.KEY      = k ^ 64'h0F1E2D3C4B5A6978;
                end
            end else begin
                stalled = bus.rk_valid;
                pk = bus.round_key;
                pi = bus.round_idx;
                pl = bus.rk_last;
            end
            tick();
            n_cyc++;
            bus.key_load = 1'b0;
            if (n_xfer > 0 && n_xfer < 16) chk("busy_held", 64'(bus.busy), 64'd1);
            if (n_xfer == abort_at) begin
                bus.rk_ready = 1'b0;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("abort_valid", 64'(bus.rk_valid), 64'd0);
                chk("abort_busy", 64'(bus.busy), 64'd0);
                chk("abort_idx", 64'(bus.round_idx), 64'd0);
                sb.delete();
                aborted = 1'b1;
                break;
            end
        end
        bus.rk_ready = 1'b0;
        if (!aborted) begin
            chk("xfer_count", 64'(n_xfer), 64'd16);
            chk("end_valid", 64'(bus.rk_valid), 64'd0);
            chk("end_busy", 64'(bus.busy), 64'd0);
            chk("end_last", 64'(bus.rk_last), 64'd0);
            chk("cd_final", 64'({dut.r_c, dut.r_d}), 64'(m_pc1(k)));
            if (rdy_pct >= 100) chk("throughput", 64'(n_cyc), 64'd16);
            if (b2b) begin
                tick();
                chk("b2b_ignored", 64'(bus.rk_valid), 64'd0);
            end
        end
    endtask

    initial begin
        bus.KEY           = '0;
        bus.key_load      = 1'b0;
        bus.mode_override = 1'b0;
        bus.mode_decrypt  = 1'b0;
        bus.rk_ready      = 1'b0;
        rst_n             = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(bus.rk_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_last", 64'(bus.rk_last), 64'd0);
        chk("rst_idx", 64'(bus.round_idx), 64'd0);
        chk("rst_key", 64'(bus.round_key), 64'd0);
        rst_n = 1'b1;
        tick();

        // Default decrypt, no backpressure
        run(K0, 1'b0, 1'b0, 1'b1, 100, -1, -1, 1'b0);
        chk("dec_k16", 64'(got[0]), 64'h0000CB3D8B0E17F5);
        chk("dec_k15", 64'(got[1]), 64'h0000BF918D3D3F0A);
        chk("dec_k1", 64'(got[15]), 64'h00001B02EFFC7072);
        tick();

        // Forced encrypt, load held high on the last transfer
        run(K0, 1'b1, 1'b0, 1'b0, 100, -1, -1, 1'b1);
        chk("enc_k1", 64'(got[0]), 64'h00001B02EFFC7072);
        chk("enc_k2", 64'(got[1]), 64'h000079AED9DBC9E5);
        chk("enc_k16", 64'(got[15]), 64'h0000CB3D8B0E17F5);
        tick();

        // Backpressure and ignored reload with a different key
        run(K0, 1'b0, 1'b0, 1'b1, 50, -1, -1, 1'b0);
        tick();
        run(K0, 1'b0, 1'b0, 1'b1, 70, 5, -1, 1'b0);
        tick();

        // Reset mid-schedule, then a fresh schedule
        run(K0, 1'b0, 1'b0, 1'b1, 100, -1, 7, 1'b0);
        chk("abort_nxfer", 64'(n_xfer), 64'd7);
        tick();
        run(K0, 1'b0, 1'b0, 1'b1, 100, -1, -1, 1'b0);
        chk("restart_k16", 64'(got[0]), 64'h0000CB3D8B0E17F5);
        tick();

        // Parity bits must not influence the schedule
        run(K1, 1'b1, 1'b1, 1'b1, 60, -1, -1, 1'b0);
        for (int i = 0; i < 16; i++) sav[i] = got[i];
        tick();
        run(K1 ^ PAR, 1'b1, 1'b1, 1'b1, 60, -1, -1, 1'b0);
        for (int i = 0; i < 16; i++) chk("parity_seq", 64'(got[i]), 64'(sav[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential DES key scheduler. Produces the 16 48-bit round keys one per accepted handshake, instead of as 16 parallel combinational outputs.
- Sits directly upstream of an iterative single-round DES datapath (encrypt or decrypt). Feeds it one round key per round.
- Decrypt mode emits K16..K1 by rotating right. Encrypt mode emits K1..K16 by rotating left. No key storage array is needed.

Parameters:
- DECRYPT_DEFAULT, 1, mode used when key_load is asserted with mode_override=0 (1 = K16 first, 0 = K1 first).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- KEY  input  64  DES key; bit 63 = DES bit 1; parity bits 8,16,...,64 ignored
- key_load  input  1  start a schedule; sampled only in IDLE
- mode_override  input  1  1 = use mode_decrypt input; 0 = use DECRYPT_DEFAULT
- mode_decrypt  input  1  requested order when mode_override=1
- rk_ready  input  1  downstream accepts round_key this cycle
- rk_valid  output  1  round_key/round_idx valid
- round_key  output  48  current round key Ki; bit 47 = PC-2 output bit 1
- round_idx  output  4  i-1 of the key presented (0 = K1, 15 = K16)
- rk_last  output  1  high with the 16th key of the schedule
- busy  output  1  high from key_load acceptance until the 16th key is accepted

Behaviour:
- One clock domain. Reset is synchronous, active-low: rst_n=0 at a rising clk edge forces state IDLE, rk_valid=0, busy=0, rk_last=0, round_idx=0, C/D registers=0 (round_key=PC2(0)=0).
- Reset mid-schedule aborts immediately. No further keys; the next key_load restarts from scratch.
- Datapath: 28-bit C and D registers.
  - round_key = PC2({C,D}), pure wiring from flops.
  - Shift schedule s1..s16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- States: IDLE, EMIT.
- IDLE:
  - busy=0, rk_valid=0. key_load=1 latches mode.
  - Encrypt: {C,D} <= {rotl(PC1_C,1), rotl(PC1_D,1)}; round_idx <= 0.
  - Decrypt: {C,D} <= PC1(KEY) unshifted (C16=C0, total shift 28); round_idx <= 15.
  - Go to EMIT. busy=1 and rk_valid=1 from the next cycle; latency key_load -> first key = 1 cycle.
- EMIT, transfer occurs when rk_valid & rk_ready:
  - Encrypt: round_idx += 1; C,D rotl by s(round_idx+2).
  - Decrypt: C,D rotr by s(round_idx+1), i.e. the shift of the key just sent; round_idx -= 1.
- EMIT, no transfer: all outputs held stable (valid/ready rule; rk_valid never drops without a transfer).
- rk_last=1 exactly when presenting the 16th key (idx 15 in encrypt, idx 0 in decrypt).
- Transfer with rk_last=1: next state IDLE, rk_valid=0, busy=0, rk_last=0. Back-to-back key_load in that same cycle is ignored; key_load is honoured only while in IDLE.
- key_load while busy: ignored; KEY changes while busy do not affect the schedule (key latched via PC-1 at load).
- Throughput: with rk_ready held high, 16 keys in 16 consecutive cycles; the next load is possible one cycle after the last transfer.
- Wrap-around: round_idx never wraps; the FSM exits before increment past 15 or decrement below 0.
- After a full schedule, C/D end at the original PC-1 value (cumulative shift 28) in both modes; the bench may check this via an internal probe.

Test Plan:
- Decrypt, KEY=0x133457799BBCDFF1, rk_ready=1 -> first key at load+1: round_key=0xCB3D8B0E17F5, round_idx=15; next 0xBF918D3D3F0A, idx 14; 16th key 0x1B02EFFC7072, idx 0, rk_last=1; busy falls on the following cycle.
- Encrypt (mode_override=1, mode_decrypt=0), same KEY -> K1=0x1B02EFFC7072 idx 0, K2=0x79AED9DBC9E5 idx 1, K16=0xCB3D8B0E17F5 idx 15 with rk_last=1.
- Backpressure: rk_ready random ~50% in decrypt mode -> stalled outputs stable, sequence identical to the unstalled run, exactly 16 transfers.
- Ignored load/KEY change: key_load pulsed with a different KEY at transfer 5 -> sequence unchanged, busy stays 1, no restart.
- Reset mid-schedule: rst_n=0 after 7 transfers -> next edge rk_valid=0, busy=0, round_idx=0; a fresh load then yields 0xCB3D8B0E17F5 first.
- Parity bits ignored: KEY=0x123456789ABCDEF0 and KEY with all parity bits inverted (XOR 0x0101010101010101) -> identical 16-key sequences.
